writeback_unit: RTL and testbench

- Writer side of the register file: collects completed results from the ALU path and the load path, and drives the register file's single write port (registerWrite, writeAddress, writeData).
- Loads have fixed priority. ALU results that collide with a load, or that arrive while older ALU results are still pending, wait in a small in-order queue.
- Load data is lane-extracted and sign/zero-extended here before the write.

---
 rtl/wb_pkg.sv | 45 ++++
 rtl/wb_fifo.sv | 68 ++++++
 rtl/writeback_unit.sv | 158 +++++++++++++++
 tb/tb_writeback_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and load-lane extraction for the register-file writeback unit.
// The optional forwarding search is enabled with WB_FORWARD_EN.
package wb_pkg;

    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10,
        LS_RSVD = 2'b11
    } load_size_t;

    typedef struct packed {
        logic [4:0]           dest;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Little-endian lane pick followed by sign/zero extension; word (and the
    // reserved encoding) passes the raw memory word through.
    function automatic logic [WB_DATA_W-1:0] load_extend(
        input logic [WB_DATA_W-1:0] data,
        input load_size_t           size,
        input logic                 is_signed,
        input logic [1:0]           offset
    );
        logic [7:0]           b;
        logic [15:0]          h;
        logic [WB_DATA_W-1:0] r;
        case (offset)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = offset[1] ? data[31:16] : data[15:0];
        case (size)
            LS_BYTE: r = {{24{is_signed & b[7]}}, b};
            LS_HALF: r = {{16{is_signed & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order pending queue for ALU results waiting on the register-file port.
// With WB_FORWARD_EN the storage and write pointer are exported for forwarding.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    input  logic                        flush,
    output wb_entry_t                   head,
    output logic [CW-1:0]               count,
    output logic                        full,
    output logic                        empty
`ifdef WB_FORWARD_EN
    ,
    output wb_entry_t [FIFO_DEPTH-1:0]  entries,
    output logic [AW-1:0]               wr_ptr_o
`endif
);

    wb_entry_t [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]              rd_ptr;
    logic [AW-1:0]              wr_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

`ifdef WB_FORWARD_EN
    assign entries  = mem;
    assign wr_ptr_o = wr_ptr;
`endif

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writer: loads win the single write port, ALU results queue in order.
// Defining WB_FORWARD_EN adds two combinational forwarding lookup ports.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [4:0]        ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [1:0]        ld_offset,
    input  logic              flush,
    output logic              registerWrite,
    output logic [4:0]        writeAddress,
    output logic [DATA_W-1:0] writeData,
    output logic              pending
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]        fwd_addr0,
    input  logic [4:0]        fwd_addr1,
    output logic              fwd_hit0,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data0,
    output logic [DATA_W-1:0] fwd_data1
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t     alu_entry;
    wb_entry_t     ld_entry;
    wb_entry_t     head;
    wb_entry_t     issue_entry;
    logic          push;
    logic          pop;
    logic          issue;
    logic          alu_fire;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

`ifdef WB_FORWARD_EN
    wb_entry_t [FIFO_DEPTH-1:0] entries;
    logic [AW-1:0]              wr_ptr;
`endif

    assign alu_ready = !full;
    assign alu_entry = '{dest: alu_dest, data: alu_data};
    assign ld_entry  = '{dest: ld_dest,
                         data: load_extend(ld_data, load_size_t'(ld_size), ld_signed, ld_offset)};

    // A handshake on flush or to r0 completes but the result is dropped.
    assign alu_fire = alu_valid && alu_ready && !flush && (alu_dest != 5'd0);

    always_comb begin
        push        = 1'b0;
        pop         = 1'b0;
        issue       = 1'b0;
        issue_entry = alu_entry;
        if (ld_valid) begin
            issue       = (ld_dest != 5'd0);
            issue_entry = ld_entry;
            push        = alu_fire;
        end else if (!empty && !flush) begin
            issue       = 1'b1;
            issue_entry = head;
            pop         = 1'b1;
            push        = alu_fire;
        end else if (alu_fire) begin
            issue       = 1'b1;
            issue_entry = alu_entry;
        end
    end

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (alu_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef WB_FORWARD_EN
        ,
        .entries    (entries),
        .wr_ptr_o   (wr_ptr)
`endif
    );

    // Address/data hold their last value on idle cycles; only the strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            registerWrite <= 1'b0;
            writeAddress  <= '0;
            writeData     <= '0;
        end else begin
            registerWrite <= issue;
            if (issue) begin
                writeAddress <= issue_entry.dest;
                writeData    <= issue_entry.data;
            end
        end
    end

    assign pending = (count != '0) || registerWrite;

`ifdef WB_FORWARD_EN
    // Oldest valid entry is visited first so newer matches overwrite it; the
    // output register is treated as newest and wins over any queue entry.
    function automatic logic [DATA_W:0] fwd_search(
        input logic [4:0]                addr,
        input wb_entry_t [FIFO_DEPTH-1:0] ents,
        input logic [AW-1:0]             wp,
        input logic [CW-1:0]             cnt,
        input logic                      wr_v,
        input logic [4:0]                wr_a,
        input logic [DATA_W-1:0]         wr_d
    );
        logic [DATA_W:0] r;
        logic [AW-1:0]   idx;
        r = '0;
        for (int i = FIFO_DEPTH; i >= 1; i--) begin
            idx = wp - AW'(i);
            if ((CW'(i) <= cnt) && (ents[idx].dest == addr)) begin
                r = {1'b1, ents[idx].data};
            end
        end
        if (wr_v && (wr_a == addr)) begin
            r = {1'b1, wr_d};
        end
        if (addr == 5'd0) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        {fwd_hit0, fwd_data0} = fwd_search(fwd_addr0, entries, wr_ptr, count,
                                           registerWrite, writeAddress, writeData);
        {fwd_hit1, fwd_data1} = fwd_search(fwd_addr1, entries, wr_ptr, count,
                                           registerWrite, writeAddress, writeData);
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scoreboard bench for writeback_unit: expected writes are queued at
// stimulus time and popped by a monitor whenever registerWrite is seen.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  ld_offset;
    logic        flush;
    logic        registerWrite;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic        pending;
`ifdef WB_FORWARD_EN
    logic        fwd_hit0, fwd_hit1;
    logic [31:0] fwd_data0, fwd_data1;
`endif

    int vectors    = 0;
    int miscompares = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    writeback_unit #(.FIFO_DEPTH(4), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .ld_size       (ld_size),
        .ld_signed     (ld_signed),
        .ld_offset     (ld_offset),
        .flush         (flush),
        .registerWrite (registerWrite),
        .writeAddress  (writeAddress),
        .writeData     (writeData),
        .pending       (pending)
`ifdef WB_FORWARD_EN
        ,
        .fwd_addr0     (5'd0),
        .fwd_addr1     (5'd0),
        .fwd_hit0      (fwd_hit0),
        .fwd_hit1      (fwd_hit1),
        .fwd_data0     (fwd_data0),
        .fwd_data1     (fwd_data1)
`endif
    );

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (registerWrite !== 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got r%0d=0x%08h (strobe %b) required no write",
                             writeAddress, writeData, registerWrite);
                end else begin
                    e = exp_q.pop_front();
                    if ({writeAddress, writeData} !== e) begin
                        miscompares++;
                        $display("FAIL write_order: got r%0d=0x%08h required r%0d=0x%08h",
                                 writeAddress, writeData, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_dest  = '0; ld_data  = '0;
        ld_size   = 2'b00; ld_signed = 1'b0; ld_offset = 2'b00;
        flush     = 1'b0;
    endtask

    task automatic exp_push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic drive_load(input logic [4:0] d, input logic [31:0] w, input logic [1:0] sz,
                              input logic sg, input logic [1:0] off);
        ld_valid = 1'b1; ld_dest = d; ld_data = w;
        ld_size = sz; ld_signed = sg; ld_offset = off;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int next_dest;
        int xfers;
        int budget;
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("reset_regwrite", 32'(registerWrite), 32'd0);
        check("reset_addr", 32'(writeAddress), 32'd0);
        check("reset_data", writeData, 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_alu_ready", 32'(alu_ready), 32'd1);
        rst = 1'b0;
        tick();

        // ALU bypass into an empty queue, single-cycle strobe, held address/data
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hDEADBEEF;
        exp_push(5'd3, 32'hDEADBEEF);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("bypass_strobe", 32'(registerWrite), 32'd1);
        tick();
        @(negedge clk);
        check("bypass_one_cycle", 32'(registerWrite), 32'd0);
        check("hold_addr", 32'(writeAddress), 32'd3);
        check("hold_data", writeData, 32'hDEADBEEF);
        tick();

        // Load and ALU collide: load first, ALU result next cycle
        drive_load(5'd5, 32'h0080FF00, 2'b00, 1'b1, 2'd2);
        alu_valid = 1'b1; alu_dest = 5'd6; alu_data = 32'd1;
        exp_push(5'd5, 32'hFFFFFF80);
        exp_push(5'd6, 32'd1);
        tick();
        idle_inputs();
        repeat (4) tick();

        // Back-to-back loads covering lanes, halves, extension and r0
        drive_load(5'd23, 32'h80011234, 2'b01, 1'b1, 2'd3); exp_push(5'd23, 32'hFFFF8001); tick();
        drive_load(5'd24, 32'h1234ABCD, 2'b01, 1'b0, 2'd1); exp_push(5'd24, 32'h0000ABCD); tick();
        drive_load(5'd25, 32'hC3000000, 2'b00, 1'b0, 2'd3); exp_push(5'd25, 32'h000000C3); tick();
        drive_load(5'd26, 32'h87654321, 2'b11, 1'b1, 2'd2); exp_push(5'd26, 32'h87654321); tick();
        drive_load(5'd0,  32'hFFFFFFFF, 2'b10, 1'b0, 2'd0); tick();
        drive_load(5'd27, 32'h0000007F, 2'b00, 1'b1, 2'd0); exp_push(5'd27, 32'h0000007F); tick();
        drive_load(5'd28, 32'h00F0F0F0, 2'b01, 1'b1, 2'd0); exp_push(5'd28, 32'hFFFFF0F0); tick();
        idle_inputs();
        repeat (4) tick();

        // Loads hold the port for 5 cycles while ALU offers r7..r11
        for (int c = 0; c < 5; c++) exp_push(5'd1, 32'hA0000000 + 32'(c));
        for (int d = 7; d <= 11; d++) exp_push(5'(d), 32'h100 + 32'(d));
        next_dest = 7;
        xfers = 0;
        for (int c = 0; c < 5; c++) begin
            drive_load(5'd1, 32'hA0000000 + 32'(c), 2'b10, 1'b1, 2'd0);
            alu_valid = 1'b1; alu_dest = 5'(next_dest); alu_data = 32'h100 + 32'(next_dest);
            @(negedge clk);
            if (alu_ready) begin
                next_dest++;
                xfers++;
            end
            tick();
        end
        ld_valid = 1'b0;
        check("xfers_during_loads", 32'(xfers), 32'd4);
        budget = 0;
        while (next_dest <= 11 && budget < 20) begin
            alu_valid = 1'b1; alu_dest = 5'(next_dest); alu_data = 32'h100 + 32'(next_dest);
            @(negedge clk);
            if (alu_ready) next_dest++;
            tick();
            budget++;
        end
        check("alu_r11_accepted", 32'(next_dest), 32'd12);
        idle_inputs();
        repeat (8) tick();

        // Two queued entries, then flush alongside a load to r2
        drive_load(5'd20, 32'h20202020, 2'b10, 1'b0, 2'd0);
        alu_valid = 1'b1; alu_dest = 5'd12; alu_data = 32'hBAD0000C;
        exp_push(5'd20, 32'h20202020);
        tick();
        drive_load(5'd21, 32'h21212121, 2'b10, 1'b0, 2'd0);
        alu_dest = 5'd13; alu_data = 32'hBAD0000D;
        exp_push(5'd21, 32'h21212121);
        tick();
        drive_load(5'd2, 32'h00000222, 2'b10, 1'b0, 2'd0);
        alu_dest = 5'd14; alu_data = 32'hBAD0000E;
        flush = 1'b1;
        exp_push(5'd2, 32'h00000222);
        @(negedge clk);
        check("flush_alu_ready", 32'(alu_ready), 32'd1);
        check("flush_pending_before", 32'(pending), 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("flush_pending_on_write", 32'(pending), 32'd1);
        tick();
        @(negedge clk);
        check("flush_pending_after", 32'(pending), 32'd0);
        repeat (4) tick();

        // ALU to r0: handshake completes, nothing is written
        alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'd5;
        @(negedge clk);
        check("r0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("r0_no_write", 32'(registerWrite), 32'd0);
        check("r0_pending", 32'(pending), 32'd0);
        tick();

        // Fill the queue behind loads, then reset: queued results must vanish
        for (int c = 0; c < 4; c++) begin
            drive_load(5'd22, 32'h22000000 + 32'(c), 2'b10, 1'b0, 2'd0);
            alu_valid = 1'b1; alu_dest = 5'(15 + c); alu_data = 32'hBAD00000 + 32'(c);
            exp_push(5'd22, 32'h22000000 + 32'(c));
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_regwrite", 32'(registerWrite), 32'd0);
        check("rst_addr", 32'(writeAddress), 32'd0);
        check("rst_data", writeData, 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);
        repeat (8) tick();

        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
